// File: rtl/chdr_pkt_rr_arb.sv
// Packet-granular round-robin arbiter: muxes NUM_PORTS CHDR AXI-Stream inputs onto one output, whole packets only.
// Optional macro CHDR_ARB_TRIM_EN trims packets to the header length field and discards any excess lines.
module chdr_pkt_rr_arb #(
    parameter int CHDR_W    = 64,
    parameter int USER_W    = 16,
    parameter int NUM_PORTS = 4,
    localparam int TID_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS*CHDR_W-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*USER_W-1:0]   s_axis_tuser,
    input  logic [NUM_PORTS-1:0]          s_axis_tlast,
    input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
    output logic [NUM_PORTS-1:0]          s_axis_tready,
    output logic [CHDR_W-1:0]             m_axis_tdata,
    output logic [USER_W-1:0]             m_axis_tuser,
    output logic [TID_W-1:0]              m_axis_tid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    // Handshake: a line moves when tvalid and tready are both high on a rising clk edge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TID_W-1:0]   gnt_q, gnt_d;
    logic [TID_W-1:0]   ptr_q, ptr_d;

    logic [CHDR_W-1:0]  in_data [NUM_PORTS];
    logic [USER_W-1:0]  in_user [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign in_data[i] = s_axis_tdata[i*CHDR_W +: CHDR_W];
        assign in_user[i] = s_axis_tuser[i*USER_W +: USER_W];
    end

    logic sel_valid, sel_last, pass_hs, out_last;
    assign sel_valid = s_axis_tvalid[gnt_q];
    assign sel_last  = s_axis_tlast[gnt_q];
    assign pass_hs   = (state_q == ST_PASS) && sel_valid && m_axis_tready;

    // Round-robin search starts one past the last served port.
    logic [TID_W-1:0] cand;
    logic [TID_W-1:0] pick_idx;
    logic             pick_found;
    always_comb begin
        cand       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = TID_W'((int'(ptr_q) + k) % NUM_PORTS);
            if (!pick_found && s_axis_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef CHDR_ARB_TRIM_EN
    localparam int BPL    = CHDR_W / 8;
    localparam int BPL_SH = $clog2(BPL);

    logic [15:0] line_cnt_q, line_cnt_d;
    logic [15:0] lines_q, lines_d;
    logic [16:0] len_sum;
    logic [15:0] hdr_lines;
    logic        trim_last;

    // Header length is in bytes; a zero length still owns the header line.
    always_comb begin
        len_sum   = {1'b0, in_data[gnt_q][47:32]} + 17'(BPL - 1);
        hdr_lines = 16'(len_sum >> BPL_SH);
        if (hdr_lines == 16'd0) begin
            hdr_lines = 16'd1;
        end
        if (line_cnt_q == 16'd0) begin
            trim_last = (hdr_lines == 16'd1);
        end else begin
            trim_last = ((line_cnt_q + 16'd1) == lines_q);
        end
    end

    assign out_last = sel_last | trim_last;
`else
    assign out_last = sel_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ptr_q      <= TID_W'(NUM_PORTS - 1);
`ifdef CHDR_ARB_TRIM_EN
            line_cnt_q <= '0;
            lines_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
`ifdef CHDR_ARB_TRIM_EN
            line_cnt_q <= line_cnt_d;
            lines_q    <= lines_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
`ifdef CHDR_ARB_TRIM_EN
        line_cnt_d = line_cnt_q;
        lines_d    = lines_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    state_d = ST_PASS;
`ifdef CHDR_ARB_TRIM_EN
                    line_cnt_d = '0;
`endif
                end
            end
            ST_PASS: begin
                if (pass_hs) begin
`ifdef CHDR_ARB_TRIM_EN
                    line_cnt_d = line_cnt_q + 16'd1;
                    if (line_cnt_q == 16'd0) begin
                        lines_d = hdr_lines;
                    end
`endif
                    if (sel_last) begin
                        ptr_d   = gnt_q;
                        state_d = ST_IDLE;
`ifdef CHDR_ARB_TRIM_EN
                    end else if (trim_last) begin
                        state_d = ST_DUMP;
`endif
                    end
                end
            end
`ifdef CHDR_ARB_TRIM_EN
            ST_DUMP: begin
                if (sel_valid && sel_last) begin
                    ptr_d   = gnt_q;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced quiet while rst is high, even before state_q has returned to idle.
    always_comb begin
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        m_axis_tdata  = in_data[gnt_q];
        m_axis_tuser  = in_user[gnt_q];
        m_axis_tid    = gnt_q;
        m_axis_tlast  = out_last;
        if (!rst) begin
            case (state_q)
                ST_PASS: begin
                    m_axis_tvalid        = sel_valid;
                    s_axis_tready[gnt_q] = m_axis_tready;
                end
`ifdef CHDR_ARB_TRIM_EN
                ST_DUMP: begin
                    s_axis_tready[gnt_q] = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chdr_pkt_rr_arb.sv
// Bench for chdr_pkt_rr_arb: per-port source queues, expected-beat scoreboard, packet-order vector table.
// Trim cases are compiled only when CHDR_ARB_TRIM_EN is defined.
module tb_chdr_pkt_rr_arb;

    localparam int CHDR_W = 64;
    localparam int USER_W = 16;
    localparam int NP     = 4;
    localparam int TID_W  = 2;
    localparam int BW     = CHDR_W + USER_W + 1;
    localparam int OW     = TID_W + BW;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NP*CHDR_W-1:0]    s_axis_tdata  = '0;
    logic [NP*USER_W-1:0]    s_axis_tuser  = '0;
    logic [NP-1:0]           s_axis_tlast  = '0;
    logic [NP-1:0]           s_axis_tvalid = '0;
    logic [NP-1:0]           s_axis_tready;
    logic [CHDR_W-1:0]       m_axis_tdata;
    logic [USER_W-1:0]       m_axis_tuser;
    logic [TID_W-1:0]        m_axis_tid;
    logic                    m_axis_tlast;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready = 1'b0;

    chdr_pkt_rr_arb #(
        .CHDR_W    (CHDR_W),
        .USER_W    (USER_W),
        .NUM_PORTS (NP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    logic [BW-1:0] src_q [NP][$];
    logic [OW-1:0] exp_q [$];
    logic [NP-1:0] hold     = '0;
    int            rdy_mode = 0;
    logic          rdy_tgl  = 1'b0;
    int            checks   = 0;
    int            failures = 0;
    int            out_cnt  = 0;
    int            ncyc     = 0;
    int            last_end_cyc = 0;
    bit            have_end   = 1'b0;
    bit            pkt_first  = 1'b1;
    bit            gap_chk    = 1'b0;
    bit            prev_stall = 1'b0;
    logic [OW-1:0] prev_word  = '0;
    int            pkt_seq    = 0;
    string         cur_test   = "init";

    logic [OW-1:0] m_word;
    assign m_word = {m_axis_tid, m_axis_tuser, m_axis_tdata, m_axis_tlast};

    typedef struct packed {
        logic [2:0]      n;
        logic [3:0]      len;
        logic [3:0][1:0] order;
    } vec_t;
    vec_t vecs [6];

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        logic [BW-1:0] w;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0 && !hold[p]) begin
                w = src_q[p][0];
                s_axis_tvalid[p] = 1'b1;
                s_axis_tdata[p*CHDR_W +: CHDR_W] = w[BW-1 -: CHDR_W];
                s_axis_tuser[p*USER_W +: USER_W] = w[USER_W:1];
                s_axis_tlast[p] = w[0];
            end else begin
                s_axis_tvalid[p] = 1'b0;
                s_axis_tdata[p*CHDR_W +: CHDR_W] = '0;
                s_axis_tuser[p*USER_W +: USER_W] = '0;
                s_axis_tlast[p] = 1'b0;
            end
        end
        case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: begin
                rdy_tgl = ~rdy_tgl;
                m_axis_tready = rdy_tgl;
            end
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Queue n_src source lines; the first n_out of them are expected on the output.
    task automatic send_pkt(input int port, input int n_src, input int len_bytes, input int n_out);
        logic [CHDR_W-1:0] d;
        logic [USER_W-1:0] u;
        pkt_seq++;
        for (int b = 0; b < n_src; b++) begin
            d = {$urandom, $urandom};
            d[63:56] = 8'(port);
            d[55:48] = 8'(b);
            if (b == 0) d[47:32] = 16'(len_bytes);
            u = 16'(pkt_seq * 16 + b);
            src_q[port].push_back({d, u, (b == n_src - 1)});
            if (b < n_out) exp_q.push_back({TID_W'(port), u, d, (b == n_out - 1)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_test, name, got, exp);
        end
    endtask

    task automatic wait_out(input int target, input int budget);
        int n = 0;
        while (out_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check_val("wait_out", 32'(out_cnt >= target), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_val("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) tick();
        for (int p = 0; p < NP; p++) begin
            check_val("src_left", 32'(src_q[p].size()), 32'd0);
            src_q[p].delete();
        end
    endtask

    // Source model: handshakes sampled mid-cycle, queues advanced just after the edge.
    initial begin
        logic [NP-1:0] hs;
        drive_inputs();
        forever begin
            @(negedge clk);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            end
            drive_inputs();
        end
    end

    // ---------------- scoreboard / monitor ----------------
    initial begin
        logic [OW-1:0] w;
        logic [NP-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                prev_stall = 1'b0;
                pkt_first  = 1'b1;
                have_end   = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!m_axis_tvalid || m_word !== prev_word) begin
                        failures++;
                        $display("FAIL %s/stall_hold: got valid=%0b %h expected valid=1 %h",
                                 cur_test, m_axis_tvalid, m_word, prev_word);
                    end
                end
                if (m_axis_tvalid) begin
                    exp_rdy = m_axis_tready ? (NP'(1) << m_axis_tid) : '0;
                    checks++;
                    if (s_axis_tready !== exp_rdy) begin
                        failures++;
                        $display("FAIL %s/tready_mirror: got %b expected %b", cur_test, s_axis_tready, exp_rdy);
                    end
                    if (m_axis_tready) begin
                        if (pkt_first && gap_chk && have_end) begin
                            checks++;
                            if (ncyc - last_end_cyc != 2) begin
                                failures++;
                                $display("FAIL %s/gap: got %0d cycles expected 2", cur_test, ncyc - last_end_cyc);
                            end
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL %s/beat: got %h expected no beat", cur_test, m_word);
                        end else begin
                            w = exp_q.pop_front();
                            if (m_word !== w) begin
                                failures++;
                                $display("FAIL %s/beat: got %h expected %h", cur_test, m_word, w);
                            end
                        end
                        out_cnt++;
                        pkt_first = m_axis_tlast;
                        if (m_axis_tlast) begin
                            have_end = 1'b1;
                            last_end_cyc = ncyc;
                        end
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_word  = m_word;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int base;
        // {packet count, lines per packet, expected service order (order[0] first)}
        vecs[0] = '{3'd4, 4'd2, {2'd0, 2'd3, 2'd2, 2'd1}};
        vecs[1] = '{3'd2, 4'd3, {2'd0, 2'd0, 2'd2, 2'd1}};
        vecs[2] = '{3'd3, 4'd1, {2'd0, 2'd1, 2'd0, 2'd3}};
        vecs[3] = '{3'd2, 4'd4, {2'd0, 2'd0, 2'd0, 2'd2}};
        vecs[4] = '{3'd1, 4'd2, {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[5] = '{3'd3, 4'd1, {2'd0, 2'd3, 2'd2, 2'd1}};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        cur_test = "reset";
        @(negedge clk);
        check_val("tvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("s_tready", 32'(s_axis_tready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_val("idle_tvalid", 32'(m_axis_tvalid), 32'd0);

        // All four ports busy, port 0 has two packets: 0,1,2,3,0 with one bubble each.
        cur_test = "rr_all";
        rdy_mode = 0;
        gap_chk  = 1'b1;
        send_pkt(0, 3, 24, 3);
        send_pkt(1, 3, 24, 3);
        send_pkt(2, 3, 24, 3);
        send_pkt(3, 3, 24, 3);
        send_pkt(0, 3, 24, 3);
        wait_drain(400);
        gap_chk = 1'b0;

        // Vector table under random output backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 6; i++) begin
            cur_test = $sformatf("vec%0d", i);
            for (int j = 0; j < int'(vecs[i].n); j++) begin
                send_pkt(int'(vecs[i].order[j]), int'(vecs[i].len), int'(vecs[i].len) * 8, int'(vecs[i].len));
            end
            wait_drain(400);
        end

        // Port 2 holds grant while others arrive mid-packet; then 3,0,1.
        cur_test = "hold_grant";
        rdy_mode = 0;
        base = out_cnt;
        send_pkt(2, 4, 32, 4);
        wait_out(base + 1, 50);
        send_pkt(3, 2, 16, 2);
        send_pkt(0, 2, 16, 2);
        send_pkt(1, 2, 16, 2);
        wait_drain(400);

        // Output tready toggling during a 4-line packet.
        cur_test = "backpressure";
        rdy_mode = 1;
        rdy_tgl  = 1'b0;
        send_pkt(2, 4, 32, 4);
        wait_drain(400);
        rdy_mode = 0;

        // Source drops tvalid mid-packet: output stalls, port 0 must wait.
        cur_test = "src_stall";
        base = out_cnt;
        send_pkt(3, 3, 24, 3);
        send_pkt(0, 2, 16, 2);
        wait_out(base + 1, 50);
        hold[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("stall_tvalid", 32'(m_axis_tvalid), 32'd0);
            check_val("stall_p0_ready", 32'(s_axis_tready[0]), 32'd0);
        end
        hold[3] = 1'b0;
        wait_drain(400);

        // Reset during beat 2 of a 5-line port-1 packet.
        cur_test = "mid_reset";
        base = out_cnt;
        send_pkt(1, 5, 40, 5);
        wait_out(base + 1, 50);
        rst = 1'b1;
        exp_q.delete();
        for (int p = 0; p < NP; p++) src_q[p].delete();
        @(negedge clk);
        check_val("tvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("s_tready", 32'(s_axis_tready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        send_pkt(0, 2, 16, 2);
        send_pkt(1, 2, 16, 2);
        wait_drain(400);

`ifdef CHDR_ARB_TRIM_EN
        // Length 20 bytes -> 3 lines of 5 sent; excess dropped, then port 3.
        cur_test = "trim_dump";
        send_pkt(2, 5, 20, 3);
        send_pkt(3, 2, 16, 2);
        wait_drain(400);

        // One-line header packet and an early source tlast.
        cur_test = "trim_short";
        send_pkt(0, 1, 8, 1);
        send_pkt(1, 2, 24, 2);
        send_pkt(2, 2, 16, 2);
        wait_drain(400);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chdr_pkt_rr_arb.md
Name: chdr_pkt_rr_arb

Overview:
Packet-granular round-robin arbiter. It shares one CHDR AXI-Stream datapath between NUM_PORTS upstream CHDR requesters. A grant is held for a whole packet and is released only after the last line of that packet is handshaked. It sits ahead of the shared crossbar/egress port, so downstream logic always sees whole, non-interleaved packets tagged with their source port.

Parameters:
CHDR_W, 64, width of each CHDR tdata bus in bits (64, 128, 256 or 512)
USER_W, 16, width of each tuser bus in bits
NUM_PORTS, 4, number of input requesters (2..16)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  NUM_PORTS*CHDR_W  input data, port i at [i*CHDR_W +: CHDR_W]
s_axis_tuser  in  NUM_PORTS*USER_W  input user, port i at [i*USER_W +: USER_W]
s_axis_tlast  in  NUM_PORTS  per-port tlast
s_axis_tvalid  in  NUM_PORTS  per-port tvalid
s_axis_tready  out  NUM_PORTS  per-port tready
m_axis_tdata  out  CHDR_W  output data
m_axis_tuser  out  USER_W  output user
m_axis_tid  out  max(1,$clog2(NUM_PORTS))  index of granted port, stable for the whole packet
m_axis_tlast  out  1  output tlast
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Registers: state, grant index gnt, last-served pointer ptr.
- Reset: state=ST_IDLE, gnt=0, ptr=NUM_PORTS-1, so port 0 has top priority after reset.
- Output values during reset: m_axis_tvalid=0, all s_axis_tready=0.
- ST_IDLE:
  - m_axis_tvalid=0 and all s_axis_tready=0.
  - If any s_axis_tvalid is high, gnt <= first valid port searching ptr+1, ptr+2, ... modulo NUM_PORTS; state <= ST_PASS.
  - Arbitration decision takes 1 cycle. There is exactly one idle bubble cycle between consecutive packets.
- ST_PASS:
  - Mux only port gnt to the output: m_axis_tvalid = s_axis_tvalid[gnt]; s_axis_tready[gnt] = m_axis_tready; all other ready bits = 0.
  - m_axis_tid = gnt.
  - On an output handshake with m_axis_tlast=1: ptr <= gnt, state <= ST_IDLE.
- Grant is never revoked mid-packet. Changes to tvalid on other ports have no effect until the current packet ends.
- A requester that drops tvalid mid-packet stalls the output. It does not forfeit the grant.
- Single requester continuously valid: it is served back-to-back, with one bubble between packets.
- Fairness: every requester with pending data is served within NUM_PORTS packets.
- No combinational path from m_axis_tready to m_axis_tvalid.
- Reset asserted mid-packet: immediate return to ST_IDLE with ptr=NUM_PORTS-1. The partial packet is truncated without tlast; upstream is reset on the same rst.

Optional Feature:
Macro CHDR_ARB_TRIM_EN.
- Defined:
  - On the header line (first line of the grant), compute lines = ceil(tdata[47:32] / (CHDR_W/8)), 16-bit.
  - m_axis_tlast is asserted on line number `lines`, or earlier if s_axis_tlast arrives first. A short packet forwards its own tlast.
  - If the computed last line is handshaked while s_axis_tlast=0, enter ST_DUMP.
  - ST_DUMP: m_axis_tvalid=0, s_axis_tready[gnt]=1, and excess lines are discarded until s_axis_tlast. Then ptr <= gnt, state <= ST_IDLE.
  - lines==1: the header line itself carries m_axis_tlast.
  - lines==0 (length field 0) is treated as lines==1.
- Not defined:
  - Packet end is s_axis_tlast only.
  - ST_DUMP and the length counter are not built.

Test Plan:
1. Ports 0..3 all valid with 3-line packets, m_axis_tready=1 → m_axis_tid order 0,1,2,3,0; each packet 3 beats, 1 bubble cycle between packets, no interleave.
2. Grant held on port 2 mid-packet while port 1 raises tvalid → port 2 completes all lines first; port 1 served next only if ptr=2 ordering gives it priority (next order 3,0,1 if those are valid).
3. Backpressure: m_axis_tready toggles 1,0,1,0 during a 4-line packet → no data loss or duplication; s_axis_tready[gnt] mirrors tready; tdata stable while stalled.
4. Reset asserted during beat 2 of a 5-line port-1 packet → next cycle m_axis_tvalid=0; after release, with ports 1 and 0 valid, port 0 granted first.
5. CHDR_ARB_TRIM_EN, CHDR_W=64, length=20 bytes (3 lines) but 5 lines sent with tlast on line 5 → output 3 lines, tlast on line 3, lines 4-5 dropped with s_axis_tready=1, then next arbitration.
6. CHDR_ARB_TRIM_EN, length=8 on a 1-line packet and length=24 with early tlast on line 2 → tlast on header line; tlast on line 2, no DUMP state entered.
